// File: rtl/imm_gen_arbiter.sv
// Round-robin arbiter that shares one registered immediate generator among
// N_REQ requesters. One grant per cycle; the response returns exactly one
// cycle later to the owning requester. Unsupported opcodes are replaced by
// a NOP toward the generator and flagged back to the requester.
module imm_gen_arbiter #(
   parameter int N_REQ = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*32-1:0]   req_instr,
   output logic [N_REQ-1:0]      req_ready,
   input  logic                  flush,
   output logic [31:0]           gen_instruction,
   input  logic [31:0]           gen_imm,
   output logic [N_REQ-1:0]      resp_valid,
   output logic [31:0]           resp_imm,
   output logic                  resp_err,
   output logic                  busy,
   output logic [15:0]           conflict_cnt
);

   localparam int          PTR_W = $clog2(N_REQ);
   localparam logic [31:0] NOP   = 32'h0000_0013;

   function automatic logic is_supported(input logic [6:0] opcode);
      case (opcode)
         7'b0010011, 7'b0000011, 7'b0100011,
         7'b1100011, 7'b0110111, 7'b1101111: is_supported = 1'b1;
         default:                            is_supported = 1'b0;
      endcase
   endfunction

   logic [31:0]      instr_arr [N_REQ];
   logic [N_REQ-1:0] supported;

   logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic             pipe_valid_reg;
   logic [PTR_W-1:0] pipe_owner_reg;
   logic             pipe_err_reg;
   logic [15:0]      conflict_cnt_reg;

   logic             grant_any;
   logic [PTR_W-1:0] grant_idx;
   logic             grant_sup;
   logic             contended;
   logic             show;

   // Unpack the flat instruction bus and decode opcode support per requester
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
         assign instr_arr[gi] = req_instr[32*gi +: 32];
         assign supported[gi] = is_supported(req_instr[32*gi +: 7]);
      end
   endgenerate

   // Round-robin search starting at rr_ptr; nothing is granted in reset or flush
   always_comb begin
      logic [PTR_W-1:0] idx;
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = '0;
      if (reset && !flush) begin
         for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr_reg) + k) % N_REQ);
            if (!grant_any && req_valid[idx]) begin
               grant_any = 1'b1;
               grant_idx = idx;
            end
         end
      end
   end

   // One-hot ready, generator drive and next pointer derived from the grant
   always_comb begin
      req_ready = '0;
      if (grant_any)
         req_ready[grant_idx] = 1'b1;
      grant_sup       = supported[grant_idx];
      gen_instruction = (grant_any && grant_sup) ? instr_arr[grant_idx] : NOP;
      if (grant_any)
         rr_ptr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      else
         rr_ptr_next = rr_ptr_reg;
   end

   // Pointer and response pipeline; reset drops any entry in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_reg     <= '0;
         pipe_valid_reg <= 1'b0;
         pipe_owner_reg <= '0;
         pipe_err_reg   <= 1'b0;
      end else begin
         rr_ptr_reg     <= rr_ptr_next;
         pipe_valid_reg <= grant_any;
         if (grant_any) begin
            pipe_owner_reg <= grant_idx;
            pipe_err_reg   <= !grant_sup;
         end
      end
   end

   assign contended = ($countones(req_valid) >= 2) && !flush;

   // Saturating count of cycles where two or more requesters compete
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         conflict_cnt_reg <= '0;
      else if (contended && conflict_cnt_reg != 16'hFFFF)
         conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
   end

   // Response presentation; flush kills it and the entry is simply lost
   always_comb begin
      show       = pipe_valid_reg && !flush;
      resp_valid = show ? (N_REQ'(1) << pipe_owner_reg) : '0;
      resp_imm   = (show && !pipe_err_reg) ? gen_imm : 32'h0;
      resp_err   = show && pipe_err_reg;
   end

   assign busy         = pipe_valid_reg;
   assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_imm_gen_arbiter.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor
// pops and compares whenever the arbiter presents a response.
module tb_imm_gen_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [63:0] req_instr;
   logic [1:0]  req_ready;
   logic        flush;
   logic [31:0] gen_instruction;
   logic [31:0] gen_imm = 32'h0;
   logic [1:0]  resp_valid;
   logic [31:0] resp_imm;
   logic        resp_err;
   logic        busy;
   logic [15:0] conflict_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]  rv;
      logic [31:0] imm;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   imm_gen_arbiter #(.N_REQ(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_instr(req_instr),
      .req_ready(req_ready), .flush(flush), .gen_instruction(gen_instruction),
      .gen_imm(gen_imm), .resp_valid(resp_valid), .resp_imm(resp_imm),
      .resp_err(resp_err), .busy(busy), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // Small registered immediate generator (I, load, S and U formats only)
   function automatic logic [31:0] imm_of(input logic [31:0] i);
      case (i[6:0])
         7'b0010011, 7'b0000011: imm_of = {{20{i[31]}}, i[31:20]};
         7'b0100011:             imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
         7'b0110111:             imm_of = {i[31:12], 12'h000};
         default:                imm_of = 32'h0;
      endcase
   endfunction

   always @(posedge clk) gen_imm <= imm_of(gen_instruction);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: compare each presented response against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (resp_valid !== 2'b00) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=%b required=00", resp_valid);
         end else begin
            e = exp_q.pop_front();
            $display("resp valid=%b imm=%h err=%b", resp_valid, resp_imm, resp_err);
            chk("resp_valid", 32'(resp_valid), 32'(e.rv));
            chk("resp_imm", resp_imm, e.imm);
            chk("resp_err", 32'(resp_err), 32'(e.err));
         end
      end else begin
         chk("idle_resp_imm", resp_imm, 32'h0);
         chk("idle_resp_err", 32'(resp_err), 32'h0);
      end
   end

   // One cycle of stimulus plus the combinational/state checks for that cycle
   task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic f, input logic [1:0] er, input logic [31:0] eg,
                       input logic pu, input logic [31:0] ei, input logic ee,
                       input logic [15:0] ec, input logic eb);
      @(posedge clk);
      #1;
      req_valid = v;
      req_instr = {i1, i0};
      flush     = f;
      #1;
      $display("step valid=%b flush=%b ready=%b gen=%h cnt=%h busy=%b",
               v, f, req_ready, gen_instruction, conflict_cnt, busy);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("gen_instruction", gen_instruction, eg);
      chk("conflict_cnt", 32'(conflict_cnt), 32'(ec));
      chk("busy", 32'(busy), 32'(eb));
      if (pu) exp_q.push_back('{rv: er, imm: ei, err: ee});
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_gen_instruction", gen_instruction, 32'h0000_0013);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_imm", resp_imm, 32'h0);
      chk("rst_resp_err", 32'(resp_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_conflict_cnt", 32'(conflict_cnt), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      req_valid = 2'b11;
      req_instr = {32'hFFF0_0193, 32'h0050_0093};
      #12;
      chk_reset_outputs();
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1 reset = 1'b1;

      // single grant to requester 0: addi x1,x0,5
      step(2'b01, 32'h0050_0093, 32'h0, 1'b0, 2'b01, 32'h0050_0093, 1'b1, 32'h5, 1'b0, 16'h0, 1'b0);
      step(2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h13, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1);

      // fresh reset so the contention run starts at rr_ptr=0
      @(posedge clk); #1;
      reset = 1'b0;
      #1 reset = 1'b1;

      // both requesters contend for 4 cycles: grants 0,1,0,1
      step(2'b11, 32'h00A0_0113, 32'hFFF0_0193, 1'b0, 2'b01, 32'h00A0_0113, 1'b1, 32'hA, 1'b0, 16'd0, 1'b0);
      step(2'b11, 32'h00A0_0113, 32'hFFF0_0193, 1'b0, 2'b10, 32'hFFF0_0193, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'd1, 1'b1);
      step(2'b11, 32'h00A0_0113, 32'hFFF0_0193, 1'b0, 2'b01, 32'h00A0_0113, 1'b1, 32'hA, 1'b0, 16'd2, 1'b1);
      step(2'b11, 32'h00A0_0113, 32'hFFF0_0193, 1'b0, 2'b10, 32'hFFF0_0193, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'd3, 1'b1);

      // unsupported opcode (add) from requester 1
      step(2'b10, 32'h00A0_0113, 32'h0000_0033, 1'b0, 2'b10, 32'h13, 1'b1, 32'h0, 1'b1, 16'd4, 1'b1);
      // lui from requester 1
      step(2'b10, 32'h00A0_0113, 32'h1234_5037, 1'b0, 2'b10, 32'h1234_5037, 1'b1, 32'h1234_5000, 1'b0, 16'd4, 1'b1);
      // sw from requester 0, response killed by flush in the next cycle
      step(2'b01, 32'h0011_2223, 32'h1234_5037, 1'b0, 2'b01, 32'h0011_2223, 1'b0, 32'h0, 1'b0, 16'd4, 1'b1);
      step(2'b11, 32'h0011_2223, 32'h1234_5037, 1'b1, 2'b00, 32'h13, 1'b0, 32'h0, 1'b0, 16'd4, 1'b1);
      // rr_ptr stayed at 1 through the flush
      step(2'b11, 32'h0011_2223, 32'h1234_5037, 1'b0, 2'b10, 32'h1234_5037, 1'b1, 32'h1234_5000, 1'b0, 16'd4, 1'b0);

      // grant, then reset during the response cycle
      step(2'b01, 32'h0050_0093, 32'hFFF0_0193, 1'b0, 2'b01, 32'h0050_0093, 1'b0, 32'h0, 1'b0, 16'd5, 1'b1);
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = 2'b11;
      #1;
      chk_reset_outputs();
      req_valid = 2'b00;
      #1 reset = 1'b1;
      step(2'b11, 32'h0050_0093, 32'hFFF0_0193, 1'b0, 2'b01, 32'h0050_0093, 1'b1, 32'h5, 1'b0, 16'd0, 1'b0);
      step(2'b00, 32'h0050_0093, 32'hFFF0_0193, 1'b0, 2'b00, 32'h13, 1'b0, 32'h0, 1'b0, 16'd1, 1'b1);

      // saturation: preset counter just below the top
      #1 force dut.conflict_cnt_reg = 16'hFFFE;
      #1 release dut.conflict_cnt_reg;
      step(2'b11, 32'h0050_0093, 32'hFFF0_0193, 1'b0, 2'b10, 32'hFFF0_0193, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'hFFFE, 1'b0);
      step(2'b11, 32'h0050_0093, 32'hFFF0_0193, 1'b0, 2'b01, 32'h0050_0093, 1'b1, 32'h5, 1'b0, 16'hFFFF, 1'b1);
      step(2'b11, 32'h0050_0093, 32'hFFF0_0193, 1'b0, 2'b10, 32'hFFF0_0193, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'hFFFF, 1'b1);
      step(2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h13, 1'b0, 32'h0, 1'b0, 16'hFFFF, 1'b1);
      step(2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h13, 1'b0, 32'h0, 1'b0, 16'hFFFF, 1'b0);

      @(posedge clk); #2;
      chk("pending_responses", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_gen_arbiter.md
IMM_GEN_ARBITER -- requirements
Module: imm_gen_arbiter

Interface
REQ-001 Parameter: N_REQ, default 2, number of requesters sharing one immediate generator (range 2..8).
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (reset==0 resets).
REQ-004 Port: req_valid  input  N_REQ  per-requester instruction-valid.
REQ-005 Port: req_instr  input  N_REQ*32  per-requester instruction; requester i occupies bits [32*i+31:32*i].
REQ-006 Port: req_ready  output  N_REQ  per-requester grant; transfer occurs when req_valid[i]&&req_ready[i].
REQ-007 Port: flush  input  1  kills grant and response in the current cycle.
REQ-008 Port: gen_instruction  output  32  instruction driven to the shared immediate generator.
REQ-009 Port: gen_imm  input  32  shared generator result, registered there, valid one cycle after gen_instruction.
REQ-010 Port: resp_valid  output  N_REQ  one-hot response strobe to the owning requester.
REQ-011 Port: resp_imm  output  32  immediate for the responding requester.
REQ-012 Port: resp_err  output  1  unsupported-opcode flag for the responding requester.
REQ-013 Port: busy  output  1  a response is in flight.
REQ-014 Port: conflict_cnt  output  16  saturating count of contended cycles.

Function
REQ-015 Supported opcodes SHALL be 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111; all others are unsupported.
REQ-016 At most one req_ready bit SHALL be high per cycle; req_ready is combinational from req_valid, rr_ptr and flush.
REQ-017 Grant SHALL go to the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
REQ-018 After a grant to i, rr_ptr SHALL become (i+1) mod N_REQ; with no grant, rr_ptr is unchanged.
REQ-019 While flush=1, req_ready SHALL be all zero and rr_ptr unchanged.
REQ-020 gen_instruction SHALL equal the granted req_instr when that opcode is supported, else 32'h00000013; with no grant it SHALL be 32'h00000013.
REQ-021 On a grant in cycle N, a pipeline register SHALL capture {valid=1, owner=i, err=unsupported}; with no grant, valid is cleared.
REQ-022 In cycle N+1 with pipeline valid=1 and flush=0: resp_valid[owner]=1, resp_imm=gen_imm (32'h0 if err), resp_err=err.
REQ-023 When no response is presented, resp_valid=0, resp_imm=32'h0 and resp_err=0.
REQ-024 flush=1 in cycle N+1 SHALL suppress that cycle's response entirely; the entry is dropped and never re-presented.
REQ-025 Back-to-back grants SHALL be supported: throughput is one grant per cycle, latency exactly one cycle.
REQ-026 busy SHALL equal pipeline valid.
REQ-027 conflict_cnt SHALL increment in each cycle with two or more req_valid bits set and flush=0, saturating at 16'hFFFF.
REQ-028 Responses carry no backpressure; the requester SHALL accept in the cycle presented.

Reset
REQ-029 While reset=0: rr_ptr=0, pipeline valid=0, conflict_cnt=0, resp_valid=0, resp_imm=0, resp_err=0, busy=0, req_ready=0, gen_instruction=32'h00000013.
REQ-030 Reset asserted with an entry in flight SHALL drop that entry, with no response after reset deasserts.
REQ-031 Deassertion SHALL take effect at the first posedge with reset=1; grants are allowed in that cycle.

Verification
REQ-032 After reset, req_valid=01, req_instr[0]=32'h00500093 -> req_ready=01, gen_instruction=32'h00500093; next cycle resp_valid=01, resp_imm=gen_imm (5 with real generator), resp_err=0.
REQ-033 req_valid=11 held 4 cycles after reset -> grants 0,1,0,1, responses alternate 01,10 one cycle later, conflict_cnt=4.
REQ-034 req_instr[1]=32'h00000033 granted alone -> gen_instruction=32'h00000013; next cycle resp_valid=10, resp_err=1, resp_imm=0.
REQ-035 Grant in cycle N, flush=1 in N+1 -> resp_valid=0 in N+1, req_ready=0 in N+1, rr_ptr unchanged in N+1.
REQ-036 Grant in cycle N, reset=0 during N+1 -> no resp_valid, all outputs at reset values, rr_ptr=0 after release.
REQ-037 conflict_cnt preset to 16'hFFFE (force), req_valid=11 for 3 cycles -> conflict_cnt=16'hFFFF, holds, no wrap.
